// File: rtl/tensor_instruction_sequencer_if.sv
// Host, cpu and read-response signal bundle for the tensor instruction sequencer.
// The slave modport is the sequencer side; master is the host/cpu environment.
interface tensor_instruction_sequencer_if #(
  parameter int FIFO_DEPTH = 16
);
  logic        [15:0]               host_instruction_in;
  logic                             host_valid_in;
  logic                             host_ready_out;
  logic        [15:0]               cpu_instruction_out;
  logic signed [7:0]                cpu_output_in;
  logic        [15:0]               read_data_out;
  logic                             read_valid_out;
  logic                             read_last_out;
  logic                             busy_out;
  logic        [$clog2(FIFO_DEPTH):0] fifo_count_out;

  modport slave (
    input  host_instruction_in, host_valid_in, cpu_output_in,
    output host_ready_out, cpu_instruction_out, read_data_out,
    output read_valid_out, read_last_out, busy_out, fifo_count_out
  );

  modport master (
    output host_instruction_in, host_valid_in, cpu_output_in,
    input  host_ready_out, cpu_instruction_out, read_data_out,
    input  read_valid_out, read_last_out, busy_out, fifo_count_out
  );
endinterface

// File: rtl/tensor_instruction_sequencer.sv
// Buffers host instructions in a FIFO and issues one per cycle to the cpu tensor block,
// stalling with NOPs during burst write/read data phases and the post-operate wait.
module tensor_instruction_sequencer #(
  parameter int FIFO_DEPTH          = 16,
  parameter int OPERATE_WAIT_CYCLES = 6,
  parameter int BURST_WRITE_BEATS   = 5,
  parameter int BURST_READ_BEATS    = 9
) (
  input logic clock_in,
  input logic reset_n_in,
  tensor_instruction_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BW_NEED = CNT_W'(1 + 2 * BURST_WRITE_BEATS);

  typedef enum logic [2:0] {S_INIT, S_ISSUE, S_BW_DATA, S_BR_DATA, S_OP_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_phase, w_phase_nxt;
  logic [7:0]       r_neg_byte;
  logic [15:0]      r_read_data;
  logic             r_read_valid, r_read_last;

  logic             w_ready, w_push, w_gread_issue;
  logic [1:0]       w_pop_n;
  logic [15:0]      w_head, w_head1, w_instr;
  logic             w_is_bw, w_is_br, w_is_op, w_is_gread;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head1    = r_mem[r_rd_ptr + PTR_W'(1)];
  assign w_is_bw    = (w_head[1:0] == 2'b11) &&  w_head[2];
  assign w_is_br    = (w_head[1:0] == 2'b11) && !w_head[2];
  assign w_is_op    = (w_head[1:0] == 2'b10);
  assign w_is_gread = (w_head[3:0] == 4'b1000);
  assign w_ready    = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push     = bus.host_valid_in && w_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_pop_n       = 2'd0;
    w_instr       = 16'h0000;
    w_gread_issue = 1'b0;
    case (r_state)
      S_INIT: begin
        w_instr     = 16'h000C;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // A burst-write header waits until all of its data words are buffered.
        if (r_count != '0 && !(w_is_bw && r_count < BW_NEED)) begin
          w_instr       = w_head;
          w_pop_n       = 2'd1;
          w_phase_nxt   = 8'd0;
          w_gread_issue = w_is_gread;
          if (w_is_bw)      w_state_nxt = S_BW_DATA;
          else if (w_is_br) w_state_nxt = S_BR_DATA;
          else if (w_is_op) w_state_nxt = S_OP_WAIT;
        end
      end
      S_BW_DATA: begin
        // cpu captures A on the falling edge and B on the rising edge.
        w_instr     = clock_in ? w_head : w_head1;
        w_pop_n     = 2'd2;
        w_phase_nxt = r_phase + 8'd1;
        if (r_phase == 8'(BURST_WRITE_BEATS - 1)) w_state_nxt = S_ISSUE;
      end
      S_BR_DATA: begin
        w_phase_nxt = r_phase + 8'd1;
        if (r_phase == 8'(BURST_READ_BEATS - 1)) w_state_nxt = S_ISSUE;
      end
      S_OP_WAIT: begin
        w_phase_nxt = r_phase + 8'd1;
        if (r_phase == 8'(OPERATE_WAIT_CYCLES - 1)) w_state_nxt = S_ISSUE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state  <= S_INIT;
      r_phase  <= 8'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop_n);
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.host_instruction_in;
  end

  // Mid-cycle sample of cpu output forms the high byte of each burst-read beat.
  always_ff @(negedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) r_neg_byte <= 8'd0;
    else             r_neg_byte <= bus.cpu_output_in;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_read_data  <= 16'h0000;
      r_read_valid <= 1'b0;
      r_read_last  <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_read_last  <= 1'b0;
      if (r_state == S_BR_DATA) begin
        r_read_data  <= {r_neg_byte, bus.cpu_output_in};
        r_read_valid <= 1'b1;
        r_read_last  <= (r_phase == 8'(BURST_READ_BEATS - 1));
      end else if (w_gread_issue) begin
        r_read_data  <= {8'h00, bus.cpu_output_in};
        r_read_valid <= 1'b1;
        r_read_last  <= 1'b1;
      end
    end
  end

  assign bus.host_ready_out      = w_ready;
  assign bus.cpu_instruction_out = w_instr;
  assign bus.read_data_out       = r_read_data;
  assign bus.read_valid_out      = r_read_valid;
  assign bus.read_last_out       = r_read_last;
  assign bus.busy_out            = (r_state != S_ISSUE);
  assign bus.fifo_count_out      = r_count;
endmodule
